// File: rtl/fetch_unit.sv
// fetch_unit: MIPS PC sequencing and instruction fetch over a valid/ready memory port,
// holding each instruction for the decoder and trapping on unsupported opcodes.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic        instr_valid,
   output logic [31:0] pc,
   input  logic [1:0]  branch,
   input  logic        jump,
   input  logic        zero,
   input  logic        stall,
   output logic        trap
);
   typedef enum logic [1:0] {FETCH, EXEC, TRAP} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, instr_d;
   logic [31:0] pcplus4, br_target, next_pc;
   logic        taken, legal;

   assign pcplus4   = pc_q + 32'd4;
   assign br_target = pcplus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   assign taken     = branch[1] & (zero ^ branch[0]);
   assign next_pc   = jump ? {pcplus4[31:28], instr_q[25:0], 2'b00} : taken ? br_target : pcplus4;
   assign legal     = instr_q[31:26] inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                             6'b001000, 6'b000010, 6'b001101, 6'b000101};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (state_q)
         FETCH: if (imem_ready) begin
            instr_d = imem_rdata;
            state_d = EXEC;
         end
         EXEC: if (!legal) begin
            state_d = TRAP;
         end else if (!stall) begin
            pc_d    = next_pc;
            state_d = FETCH;
         end
         default: state_d = (state_q == TRAP) ? TRAP : FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   // Reset gates the handshake outputs so no request or valid leaks out while resetting
   assign imem_req    = (state_q == FETCH) && !reset;
   assign instr_valid = (state_q == EXEC) && !reset;
   assign trap        = (state_q == TRAP);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign op          = instr_q[31:26];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; expected fetch addresses are queued when each
// instruction's controls are driven and popped when the DUT issues its next request.
module tb_fetch_unit;
   logic        clk = 0, reset = 1, imem_ready = 0, jump = 0, zero = 0, stall = 0;
   logic [31:0] imem_rdata = 0;
   logic [1:0]  branch = 0;
   logic        imem_req, instr_valid, trap;
   logic [31:0] imem_addr, instr, pc;
   logic [5:0]  op;
   int          checks = 0, failures = 0, cyc = 0;
   logic [31:0] exp_q[$];

   typedef struct packed {
      logic [31:0] word;
      logic [1:0]  br;
      logic        jp;
      logic        z;
      logic [31:0] nxt;
   } step_t;

   localparam logic [31:0] ADDI = 32'h2008_0001;
   localparam logic [31:0] BAD  = 32'hFC00_0000;

   fetch_unit dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .op(op),
      .instr_valid(instr_valid), .pc(pc), .branch(branch), .jump(jump), .zero(zero),
      .stall(stall), .trap(trap)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] jw(input logic [25:0] idx);
      return {6'b000010, idx};
   endfunction

   function automatic logic [31:0] bw(input logic [5:0] o, input logic [15:0] imm);
      return {o, 10'd0, imm};
   endfunction

   function automatic logic [31:0] pop_exp();
      return exp_q.size() != 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
   endfunction

   // Memory model: waits (bounded) for a request, holds ready low for 'waits' cycles, then returns word
   task automatic serve(input logic [31:0] word, input int waits, output logic [31:0] addr,
                        output logic ok, output int reqc, output int t);
      ok = 0; reqc = 0; addr = 0; t = 0; imem_ready = 0;
      for (int n = 0; n < 20 && imem_req !== 1'b1; n++) @(negedge clk);
      if (imem_req !== 1'b1) return;
      ok = 1; addr = imem_addr; t = cyc; reqc = 1;
      for (int w = 0; w < waits; w++) begin
         @(negedge clk);
         if (imem_req === 1'b1 && imem_addr === addr) reqc++;
      end
      imem_ready = 1; imem_rdata = word;
      @(negedge clk);
      imem_ready = 0; imem_rdata = 0;
   endtask

   task automatic exec_instr(input logic [31:0] word, input int waits, input int stalls,
                             input logic [1:0] br, input logic jp, input logic z,
                             output logic [31:0] addr, output logic ok, output int reqc,
                             output int validc, output logic pch, output int t,
                             output logic [31:0] gi, output logic [5:0] go);
      logic [31:0] pc0;
      serve(word, waits, addr, ok, reqc, t);
      gi = instr; go = op; pc0 = pc; pch = 1; validc = 0;
      branch = br; jump = jp; zero = z;
      for (int s = 0; s <= stalls; s++) begin
         stall = (s < stalls);
         if (instr_valid === 1'b1) validc++;
         if (pc !== pc0) pch = 0;
         @(negedge clk);
      end
      stall = 0; branch = 0; jump = 0; zero = 0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (pc !== 32'd0 || instr !== 32'd0) begin failures++; $display("FAIL reset_state got pc=%h instr=%h want pc=0 instr=0", pc, instr); end
      checks++; if (trap !== 1'b0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL reset_outputs got trap=%b valid=%b req=%b want 0 0 0", trap, instr_valid, imem_req); end
      reset = 0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin failures++; $display("FAIL reset_first_req got req=%b addr=%h want 1 00000000", imem_req, imem_addr); end
      reset = 1; imem_ready = 1; imem_rdata = BAD;
      #1;
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL reset_forces_req got req=%b valid=%b want 0 0", imem_req, instr_valid); end
      @(negedge clk);
      checks++; if (instr !== 32'd0 || pc !== 32'd0 || trap !== 1'b0) begin failures++; $display("FAIL reset_ignores_ready got instr=%h pc=%h trap=%b want 0 0 0", instr, pc, trap); end
      reset = 0; imem_ready = 0; imem_rdata = 0;
      exp_q.push_back(32'd0);
   endtask

   task automatic test_sequential();
      logic [31:0] a, e, gi; logic [5:0] go; logic ok, ph; int rc, vc, t, tp;
      tp = 0;
      for (int i = 0; i < 3; i++) begin
         exec_instr(ADDI, 0, 0, 2'b00, 1'b0, 1'b0, a, ok, rc, vc, ph, t, gi, go);
         e = pop_exp();
         checks++; if (!ok || a !== e) begin failures++; $display("FAIL seq_addr[%0d] got=%h want=%h", i, a, e); end
         checks++; if (gi !== ADDI || go !== 6'b001000) begin failures++; $display("FAIL seq_instr_op[%0d] got=%h/%b want=%h/001000", i, gi, go, ADDI); end
         checks++; if (vc != 1 || instr_valid !== 1'b0) begin failures++; $display("FAIL seq_valid_pulse[%0d] got=%0d want=1", i, vc); end
         checks++; if (pc !== 32'(4 * (i + 1))) begin failures++; $display("FAIL seq_pc[%0d] got=%h want=%h", i, pc, 32'(4 * (i + 1))); end
         if (i > 0) begin
            checks++; if (t - tp != 2) begin failures++; $display("FAIL seq_period[%0d] got=%0d want=2", i, t - tp); end
         end
         tp = t;
         exp_q.push_back(32'(4 * (i + 1)));
      end
   endtask

   task automatic test_branch();
      logic [31:0] a, e, gi; logic [5:0] go; logic ok, ph; int rc, vc, t;
      step_t s [8] = '{
         '{jw(26'h40),                  2'b00, 1'b1, 1'b0, 32'h0000_0100},
         '{bw(6'b000100, 16'hFFFE),     2'b10, 1'b0, 1'b1, 32'h0000_00FC},
         '{jw(26'h40),                  2'b00, 1'b1, 1'b0, 32'h0000_0100},
         '{bw(6'b000100, 16'hFFFE),     2'b10, 1'b0, 1'b0, 32'h0000_0104},
         '{jw(26'h40),                  2'b00, 1'b1, 1'b0, 32'h0000_0100},
         '{bw(6'b000101, 16'hFFFE),     2'b11, 1'b0, 1'b0, 32'h0000_00FC},
         '{bw(6'b000100, 16'hFFFE),     2'b01, 1'b0, 1'b0, 32'h0000_0100},
         '{bw(6'b000100, 16'hFFBD),     2'b10, 1'b0, 1'b1, 32'hFFFF_FFF8}
      };
      foreach (s[i]) begin
         exec_instr(s[i].word, 0, 0, s[i].br, s[i].jp, s[i].z, a, ok, rc, vc, ph, t, gi, go);
         e = pop_exp();
         checks++; if (!ok || a !== e) begin failures++; $display("FAIL branch_addr[%0d] got=%h want=%h", i, a, e); end
         checks++; if (pc !== s[i].nxt) begin failures++; $display("FAIL branch_next_pc[%0d] got=%h want=%h", i, pc, s[i].nxt); end
         exp_q.push_back(s[i].nxt);
      end
   endtask

   task automatic test_jump();
      logic [31:0] a, e, gi; logic [5:0] go; logic ok, ph; int rc, vc, t;
      step_t s [4] = '{
         '{jw(26'h4),  2'b00, 1'b1, 1'b0, 32'hF000_0010},
         '{jw(26'h40), 2'b00, 1'b1, 1'b0, 32'hF000_0100},
         '{jw(26'h4),  2'b00, 1'b1, 1'b0, 32'hF000_0010},
         '{jw(26'h40), 2'b10, 1'b1, 1'b1, 32'hF000_0100}
      };
      foreach (s[i]) begin
         exec_instr(s[i].word, 0, 0, s[i].br, s[i].jp, s[i].z, a, ok, rc, vc, ph, t, gi, go);
         e = pop_exp();
         checks++; if (!ok || a !== e) begin failures++; $display("FAIL jump_addr[%0d] got=%h want=%h", i, a, e); end
         checks++; if (pc !== s[i].nxt) begin failures++; $display("FAIL jump_next_pc[%0d] got=%h want=%h", i, pc, s[i].nxt); end
         exp_q.push_back(s[i].nxt);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] a, e, gi; logic [5:0] go; logic ok, ph; int rc, vc, t;
      step_t s [2] = '{
         '{jw(26'h3FF_FFFF), 2'b00, 1'b1, 1'b0, 32'hFFFF_FFFC},
         '{ADDI,             2'b00, 1'b0, 1'b0, 32'h0000_0000}
      };
      foreach (s[i]) begin
         exec_instr(s[i].word, 0, 0, s[i].br, s[i].jp, s[i].z, a, ok, rc, vc, ph, t, gi, go);
         e = pop_exp();
         checks++; if (!ok || a !== e) begin failures++; $display("FAIL wrap_addr[%0d] got=%h want=%h", i, a, e); end
         checks++; if (pc !== s[i].nxt) begin failures++; $display("FAIL wrap_next_pc[%0d] got=%h want=%h", i, pc, s[i].nxt); end
         exp_q.push_back(s[i].nxt);
      end
   endtask

   task automatic test_handshake_stall();
      logic [31:0] a, e, gi; logic [5:0] go; logic ok, ph; int rc, vc, t;
      exec_instr(ADDI, 3, 2, 2'b00, 1'b0, 1'b0, a, ok, rc, vc, ph, t, gi, go);
      e = pop_exp();
      checks++; if (!ok || a !== e) begin failures++; $display("FAIL hs_addr got=%h want=%h", a, e); end
      checks++; if (rc != 4) begin failures++; $display("FAIL hs_req_stable_cycles got=%0d want=4", rc); end
      checks++; if (vc != 3) begin failures++; $display("FAIL stall_valid_cycles got=%0d want=3", vc); end
      checks++; if (ph !== 1'b1 || pc !== 32'd4) begin failures++; $display("FAIL stall_pc got held=%b pc=%h want held=1 pc=00000004", ph, pc); end
      exp_q.push_back(32'd4);
   endtask

   task automatic test_trap();
      logic [31:0] a, e, gi; logic [5:0] go; logic ok, ph; int rc, vc, t, bad;
      exec_instr(jw(26'h8), 0, 0, 2'b00, 1'b1, 1'b0, a, ok, rc, vc, ph, t, gi, go);
      e = pop_exp();
      checks++; if (!ok || a !== e || pc !== 32'h20) begin failures++; $display("FAIL trap_setup got addr=%h pc=%h want addr=%h pc=00000020", a, pc, e); end
      exp_q.push_back(32'h20);
      serve(BAD, 0, a, ok, rc, t);
      e = pop_exp();
      checks++; if (!ok || a !== e) begin failures++; $display("FAIL trap_addr got=%h want=%h", a, e); end
      stall = 1;
      @(negedge clk);
      stall = 0;
      checks++; if (trap !== 1'b1 || instr_valid !== 1'b0) begin failures++; $display("FAIL trap_entry got trap=%b valid=%b want 1 0", trap, instr_valid); end
      checks++; if (pc !== 32'h20 || instr !== BAD) begin failures++; $display("FAIL trap_hold got pc=%h instr=%h want 00000020 %h", pc, instr, BAD); end
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (imem_req !== 1'b0 || trap !== 1'b1 || pc !== 32'h20) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL trap_sticky got=%0d bad cycles want=0", bad); end
      reset = 1;
      @(negedge clk);
      checks++; if (pc !== 32'd0 || trap !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL trap_reset got pc=%h trap=%b req=%b want 0 0 0", pc, trap, imem_req); end
      reset = 0;
      exp_q.push_back(32'd0);
      exec_instr(ADDI, 0, 0, 2'b00, 1'b0, 1'b0, a, ok, rc, vc, ph, t, gi, go);
      e = pop_exp();
      checks++; if (!ok || a !== e || pc !== 32'd4) begin failures++; $display("FAIL trap_resume got addr=%h pc=%h want addr=%h pc=00000004", a, pc, e); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_wrap();
      test_handshake_stall();
      test_trap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
